xc_aesmix_lanes: RTL

// - Parametrised AES MixColumns / InvMixColumns unit for one 32-bit state column.
// - Computes LANES output bytes per cycle, so a column takes STEPS = 4/LANES compute cycles.
// - Registered result, explicit busy state, and abort on valid drop.
// - Sits in the XCrypto execute stage beside the other xc_* functional units. It is driven by the

---
 rtl/xc_aesmix_lanes.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/xc_aesmix_lanes.sv
//------------------------------------------------------------------------------
// Module   : xc_aesmix_lanes
// Purpose  : AES MixColumns / InvMixColumns on one 32-bit column, LANES bytes
//            per cycle, registered result with busy/ready handshake.
// Config   : XC_AESMIX_LANES_SCRUB_EN - clear result after ready and on abort.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xc_aesmix_lanes #(
   parameter int LANES = 1,
   parameter int STEPS = 4 / LANES
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        flush,
   input  logic [31:0] flush_data,
   input  logic        valid,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        enc,
   output logic        ready,
   output logic        busy,
   output logic [31:0] result
);

   localparam int c_KW = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4) || (STEPS * LANES != 4)) begin : g_bad_cfg
         $error("xc_aesmix_lanes: LANES must be 1, 2 or 4 and STEPS must be 4/LANES");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } t_state;

   function automatic logic [7:0] f_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // rot[7:0] is a_i, rot[15:8] is a_{i+1}, and so on around the column.
   function automatic logic [7:0] f_enc(input logic [31:0] rot);
      return f_xt(rot[7:0]) ^ f_xt(rot[15:8]) ^ rot[15:8] ^ rot[23:16] ^ rot[31:24];
   endfunction

   function automatic logic [7:0] f_dec(input logic [31:0] rot);
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      for (int i = 0; i < 4; i++) begin
         x2[i] = f_xt(rot[8*i +: 8]);
         x4[i] = f_xt(x2[i]);
         x8[i] = f_xt(x4[i]);
      end
      return (x8[0] ^ x4[0] ^ x2[0])
           ^ (x8[1] ^ x2[1] ^ rot[15:8])
           ^ (x8[2] ^ x4[2] ^ rot[23:16])
           ^ (x8[3] ^ rot[31:24]);
   endfunction

   t_state              r_state;
   logic [c_KW-1:0]     r_k;
   logic                r_ready;
   logic                r_busy;
   logic [31:0]         r_result;

   logic [31:0]         w_col;
   logic [1:0]          w_base;
   logic [8*LANES-1:0]  w_lanes;
   logic [31:0]         w_next;
   logic                w_unused;

   assign w_col    = {rs2[31:16], rs1[15:0]};
   assign w_base   = 2'(r_k * LANES);
   assign w_unused = ^{rs1[31:16], rs2[15:0]};

   generate
      for (genvar j = 0; j < LANES; j++) begin : g_lane
         logic [1:0]  w_idx;
         logic [31:0] w_rot;
         assign w_idx = w_base + 2'(j);
         always_comb begin
            case (w_idx)
               2'd0:    w_rot = w_col;
               2'd1:    w_rot = {w_col[7:0],  w_col[31:8]};
               2'd2:    w_rot = {w_col[15:0], w_col[31:16]};
               default: w_rot = {w_col[23:0], w_col[31:24]};
            endcase
         end
         assign w_lanes[8*j +: 8] = enc ? f_enc(w_rot) : f_dec(w_rot);
      end
   endgenerate

   always_comb begin
      w_next = r_result;
      for (int j = 0; j < LANES; j++) begin
         w_next[8*((int'(w_base) + j) % 4) +: 8] = w_lanes[8*j +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_result <= 32'h0;
      end else if (flush) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_result <= flush_data;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               if (valid) begin
                  // The acceptance cycle already writes the k=0 bytes.
                  r_result <= w_next;
                  if (STEPS == 1) begin
                     r_state <= S_DONE;
                     r_ready <= 1'b1;
                     r_k     <= '0;
                  end else begin
                     r_state <= S_COMPUTE;
                     r_busy  <= 1'b1;
                     r_k     <= c_KW'(1);
                  end
               end
            end
            S_COMPUTE: begin
               if (!valid) begin
                  r_state <= S_IDLE;
                  r_k     <= '0;
                  r_busy  <= 1'b0;
`ifdef XC_AESMIX_LANES_SCRUB_EN
                  r_result <= 32'h0;
`endif
               end else begin
                  r_result <= w_next;
                  if (r_k == c_KW'(STEPS - 1)) begin
                     r_state <= S_DONE;
                     r_k     <= '0;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                  end else begin
                     r_k <= r_k + c_KW'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
`ifdef XC_AESMIX_LANES_SCRUB_EN
               r_result <= 32'h0;
`endif
            end
            default: begin
               r_state <= S_IDLE;
               r_k     <= '0;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ready  = r_ready;
   assign busy   = r_busy;
   assign result = r_result;

endmodule

`default_nettype wire
